// File: rtl/axi_rd_burst_master_if.sv
// Handshake/bus bundle for axi_rd_burst_master.
// Groups the CPU request port, the beat response port and the AXI AR/R channels.
//   master modport : the read master's view (drives ar_*, r_ready, req_ready, rsp_*)
//   slave modport  : the environment's view (requester, consumer and AXI slave)
// Ports:
//   req_valid/req_ready/req_id/req_addr/req_len/req_size/req_signed : request
//   rsp_valid/rsp_ready/rsp_data/rsp_resp/rsp_last                  : response beats
//   ar_valid/ar_ready/ar_id/ar_addr/ar_len/ar_size/ar_burst         : AXI AR channel
//   r_valid/r_ready/r_data/r_resp/r_last/r_id                       : AXI R channel
interface axi_rd_burst_master_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned LEN_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [2:0]        req_size;
    logic              req_signed;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_resp;
    logic              rsp_last;

    logic              ar_valid;
    logic              ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;

    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic [ID_W-1:0]   r_id;

    modport master (
        input  req_valid, req_id, req_addr, req_len, req_size, req_signed,
        output req_ready,
        output rsp_valid, rsp_data, rsp_resp, rsp_last,
        input  rsp_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last, r_id,
        output r_ready
    );

    modport slave (
        output req_valid, req_id, req_addr, req_len, req_size, req_signed,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_resp, rsp_last,
        output rsp_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last, r_id,
        input  r_ready
    );
endinterface

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: takes one read request at a time, issues a single AR (single beat or
// INCR burst) and returns every R beat through a one-entry registered response port.
// Single-beat reads get byte-lane extraction (shift, mask, sign/zero extend).
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : axi_rd_burst_master_if.master (request, response, AR and R channels)
// Widths of the module parameters must match those of the connected interface.
module axi_rd_burst_master #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned LEN_W  = 8
) (
    input logic                   clk,
    input logic                   reset_n,
    axi_rd_burst_master_if.master bus
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e            state_q, state_d;
    logic              ar_valid_q, ar_valid_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [LEN_W-1:0]  ar_len_q, ar_len_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              signed_q, signed_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_last_q, rsp_last_d;

    logic              req_ready;
    logic              r_ready;
    logic              req_err;
    logic [8:0]        size_bytes;
    logic [8:0]        span;
    logic              cnt_last;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ext_data;
    logic              sign_bit;
    int                nbits;

    assign req_ready = (state_q == StIdle) && !rsp_valid_q;
    assign r_ready   = (state_q == StData) && (!rsp_valid_q || bus.rsp_ready);
    assign cnt_last  = (cnt_q == ar_len_q);

    // Request legality, evaluated on the live request at acceptance.
    always_comb begin
        size_bytes = 9'd1 << bus.req_size;
        span       = 9'(bus.req_addr[OFF_W-1:0]) + size_bytes;
        req_err    = 1'b0;
        if (32'(bus.req_size) > OFF_W) begin
            req_err = 1'b1;
        end else if (bus.req_len == '0) begin
            req_err = (span > 9'(BYTES));
        end else begin
            req_err = |(9'(bus.req_addr[7:0]) & (size_bytes - 9'd1));
        end
    end

    // Single-beat lane extraction: shift the addressed bytes down, keep 2^size bytes and
    // fill the rest with the top kept bit (signed) or zero.
    always_comb begin
        shifted  = bus.r_data >> {off_q, 3'b000};
        nbits    = 8 << ar_size_q;
        sign_bit = 1'b0;
        ext_data = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (i == nbits - 1) sign_bit = shifted[i];
        end
        for (int i = 0; i < int'(DATA_W); i++) begin
            ext_data[i] = (i < nbits) ? shifted[i] : (signed_q & sign_bit);
        end
    end

    always_comb begin
        state_d     = state_q;
        ar_valid_d  = ar_valid_q;
        ar_id_d     = ar_id_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_size_d   = ar_size_q;
        off_d       = off_q;
        signed_d    = signed_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_last_d  = rsp_last_q;

        // Consumption first so that a same-cycle load below wins (no bubble).
        if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && req_ready) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_resp_d  = 2'b10;
                        rsp_last_d  = 1'b1;
                    end else begin
                        ar_valid_d = 1'b1;
                        ar_id_d    = bus.req_id;
                        ar_len_d   = bus.req_len;
                        ar_size_d  = bus.req_size;
                        off_d      = bus.req_addr[OFF_W-1:0];
                        signed_d   = bus.req_signed;
                        ar_addr_d  = (bus.req_len == '0) ?
                                     {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} :
                                     bus.req_addr;
                        state_d    = StAddr;
                    end
                end
            end
            StAddr: begin
                if (bus.ar_ready) begin
                    ar_valid_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                if (bus.r_valid && r_ready) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = (ar_len_q == '0) ? ext_data : bus.r_data;
                    rsp_resp_d  = ((bus.r_id != ar_id_q) || (bus.r_last != cnt_last)) ?
                                  2'b10 : bus.r_resp;
                    rsp_last_d  = bus.r_last || cnt_last;
                    cnt_d       = cnt_q + 1'b1;
                    if (bus.r_last || cnt_last) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ar_valid_q  <= 1'b0;
            ar_id_q     <= '0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            ar_size_q   <= '0;
            off_q       <= '0;
            signed_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_valid_q  <= ar_valid_d;
            ar_id_q     <= ar_id_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            ar_size_q   <= ar_size_d;
            off_q       <= off_d;
            signed_q    <= signed_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.r_ready   = r_ready;
    assign bus.ar_valid  = ar_valid_q;
    assign bus.ar_id     = ar_id_q;
    assign bus.ar_addr   = ar_addr_q;
    assign bus.ar_len    = ar_len_q;
    assign bus.ar_size   = ar_size_q;
    assign bus.ar_burst  = 2'b01;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_resp  = rsp_resp_q;
    assign bus.rsp_last  = rsp_last_q;
endmodule

// File: tb/tb_axi_rd_burst_master.sv
// Self-checking bench for axi_rd_burst_master (DATA_W=64, ADDR_W=64, ID_W=4, LEN_W=8).
// Expected response beats are queued when stimulus is driven and checked by a monitor
// as the response port hands them off.
module tb_axi_rd_burst_master;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    axi_rd_burst_master_if #(.DATA_W(64), .ADDR_W(64), .ID_W(4), .LEN_W(8)) bus ();

    axi_rd_burst_master #(.DATA_W(64), .ADDR_W(64), .ID_W(4), .LEN_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    int checks = 0;
    int errors = 0;

    // Beat table used by stream()
    logic [63:0] bd [8];
    logic [1:0]  br [8];
    logic        bl [8];
    logic [3:0]  bi [8];

    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: data=%h resp=%b last=%b, required no beat",
                         bus.rsp_data, bus.rsp_resp, bus.rsp_last);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.rsp_data !== mon_exp.data || bus.rsp_resp !== mon_exp.resp ||
                    bus.rsp_last !== mon_exp.last) begin
                    errors++;
                    $display("FAIL rsp_beat: got data=%h resp=%b last=%b, required %h %b %b",
                             bus.rsp_data, bus.rsp_resp, bus.rsp_last,
                             mon_exp.data, mon_exp.resp, mon_exp.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [3:0] id, input logic [63:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic sgn);
        int n = 0;
        bus.req_valid  = 1'b1;
        bus.req_id     = id;
        bus.req_addr   = addr;
        bus.req_len    = len;
        bus.req_size   = size;
        bus.req_signed = sgn;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL req_accept: req_ready=%b after 50 cycles, required 1", bus.req_ready);
        end
        tick();
        // Scramble the request inputs; the DUT must use its latched copy.
        bus.req_valid  = 1'b0;
        bus.req_id     = ~id;
        bus.req_addr   = ~addr;
        bus.req_len    = 8'hA5;
        bus.req_size   = 3'd7;
        bus.req_signed = ~sgn;
    endtask

    task automatic ar_handshake();
        bus.ar_ready = 1'b1;
        tick();
        bus.ar_ready = 1'b0;
    endtask

    // Drives n beats from the table; rsp_ready is low on cycles lo..hi.
    // viol counts r_ready asserted while the output register is full and not draining,
    // plus 1000 if the beats could not all be delivered.
    task automatic stream(input int n, input int lo, input int hi, output int viol);
        int sent = 0;
        int cyc = 0;
        viol = 0;
        while (sent < n && cyc < 100) begin
            bus.rsp_ready = !(cyc >= lo && cyc <= hi);
            bus.r_valid   = 1'b1;
            bus.r_data    = bd[sent];
            bus.r_resp    = br[sent];
            bus.r_last    = bl[sent];
            bus.r_id      = bi[sent];
            #1;
            if (bus.rsp_valid && !bus.rsp_ready && bus.r_ready) viol++;
            if (bus.r_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sent < n) viol += 1000;
        bus.r_valid   = 1'b0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        bus.rsp_ready = 1'b1;
        while ((bus.rsp_valid || sb.size() != 0) && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.ar_valid, bus.r_ready, bus.rsp_valid, bus.rsp_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ar_valid/r_ready/rsp_valid/rsp_last=%b%b%b%b, required 0000",
                     bus.ar_valid, bus.r_ready, bus.rsp_valid, bus.rsp_last);
        end
        checks++;
        if (bus.rsp_data !== 64'd0 || bus.rsp_resp !== 2'b00) begin
            errors++;
            $display("FAIL reset_rsp: data=%h resp=%b, required 0 00", bus.rsp_data, bus.rsp_resp);
        end
        checks++;
        if (bus.ar_id !== 4'd0 || bus.ar_addr !== 64'd0 || bus.ar_len !== 8'd0 ||
            bus.ar_size !== 3'd0 || bus.ar_burst !== 2'b01) begin
            errors++;
            $display("FAIL reset_ar: id=%h addr=%h len=%h size=%h burst=%b, required 0 0 0 0 01",
                     bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b, required 1", bus.req_ready);
        end
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic        sgn;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic        bad_id;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        logic [63:0] exp_ar;
    } sb_case_t;

    task automatic test_single_beat();
        sb_case_t tc [7];
        int viol;
        logic [3:0] id;
        tc[0] = '{64'h8000_0000, 3'd3, 1'b0, 64'h1122_3344_5566_7788, 2'b00, 1'b0,
                  64'h1122_3344_5566_7788, 2'b00, 64'h8000_0000};
        tc[1] = '{64'h8000_0005, 3'd0, 1'b1, 64'h0000_F000_0000_0000, 2'b00, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFF0, 2'b00, 64'h8000_0000};
        tc[2] = '{64'h8000_0005, 3'd0, 1'b0, 64'h0000_F000_0000_0000, 2'b00, 1'b0,
                  64'h0000_0000_0000_00F0, 2'b00, 64'h8000_0000};
        tc[3] = '{64'h8000_0004, 3'd2, 1'b1, 64'h8765_4321_0000_0000, 2'b00, 1'b0,
                  64'hFFFF_FFFF_8765_4321, 2'b00, 64'h8000_0000};
        tc[4] = '{64'h8000_0002, 3'd1, 1'b0, 64'h0000_0000_BEEF_0000, 2'b01, 1'b0,
                  64'h0000_0000_0000_BEEF, 2'b01, 64'h8000_0000};
        tc[5] = '{64'h8000_0003, 3'd0, 1'b1, 64'h0000_0000_7F00_0000, 2'b11, 1'b0,
                  64'h0000_0000_0000_007F, 2'b11, 64'h8000_0000};
        tc[6] = '{64'h8000_0008, 3'd3, 1'b0, 64'hCAFE_F00D_1234_5678, 2'b00, 1'b1,
                  64'hCAFE_F00D_1234_5678, 2'b10, 64'h8000_0008};
        for (int c = 0; c < 7; c++) begin
            id = 4'(c + 1);
            issue_req(id, tc[c].addr, 8'd0, tc[c].size, tc[c].sgn);
            checks++;
            if (bus.ar_valid !== 1'b1 || bus.ar_addr !== tc[c].exp_ar || bus.ar_len !== 8'd0 ||
                bus.ar_size !== tc[c].size || bus.ar_id !== id || bus.ar_burst !== 2'b01) begin
                errors++;
                $display("FAIL single_ar[%0d]: valid=%b addr=%h len=%h size=%h id=%h, required 1 %h 0 %h %h",
                         c, bus.ar_valid, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_id,
                         tc[c].exp_ar, tc[c].size, id);
            end
            sb.push_back('{tc[c].exp_data, tc[c].exp_resp, 1'b1});
            ar_handshake();
            checks++;
            if (bus.ar_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_ar_drop[%0d]: ar_valid=%b, required 0", c, bus.ar_valid);
            end
            bd[0] = tc[c].rdata;
            br[0] = tc[c].rresp;
            bl[0] = 1'b1;
            bi[0] = tc[c].bad_id ? ~id : id;
            stream(1, 100, -1, viol);
            drain();
            checks++;
            if (viol != 0 || bus.req_ready !== 1'b1 || sb.size() != 0) begin
                errors++;
                $display("FAIL single_done[%0d]: viol=%0d req_ready=%b pending=%0d, required 0 1 0",
                         c, viol, bus.req_ready, sb.size());
            end
        end
    endtask

    task automatic test_burst_backpressure();
        int viol;
        issue_req(4'd5, 64'h8000_0100, 8'd3, 3'd3, 1'b0);
        checks++;
        if (bus.ar_addr !== 64'h8000_0100 || bus.ar_len !== 8'd3 || bus.ar_size !== 3'd3) begin
            errors++;
            $display("FAIL burst_ar: addr=%h len=%h size=%h, required 80000100 03 3",
                     bus.ar_addr, bus.ar_len, bus.ar_size);
        end
        for (int b = 0; b < 4; b++) begin
            bd[b] = 64'hD0D0_0000_0000_0000 + 64'(b) * 64'h0101_0101;
            br[b] = 2'b00;
            bl[b] = (b == 3);
            bi[b] = 4'd5;
            sb.push_back('{bd[b], 2'b00, b == 3});
        end
        ar_handshake();
        stream(4, 2, 4, viol);
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL burst_r_ready: violations=%0d, required 0", viol);
        end
        drain();
        checks++;
        if (bus.req_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL burst_done: req_ready=%b pending=%0d, required 1 0",
                     bus.req_ready, sb.size());
        end
    endtask

    task automatic test_errors();
        logic [63:0] ea [4] = '{64'h8000_0006, 64'h8000_0004, 64'h8000_0000, 64'h8000_0001};
        logic [2:0]  es [4] = '{3'd2, 3'd3, 3'd4, 3'd1};
        logic [7:0]  el [4] = '{8'd0, 8'd1, 8'd0, 8'd2};
        int ar_seen;
        int viol;
        for (int e = 0; e < 4; e++) begin
            ar_seen = 0;
            sb.push_back('{64'd0, 2'b10, 1'b1});
            bus.rsp_ready = 1'b1;
            issue_req(4'd1, ea[e], el[e], es[e], 1'b0);
            for (int k = 0; k < 4; k++) begin
                if (bus.ar_valid) ar_seen++;
                tick();
            end
            drain();
            checks++;
            if (ar_seen != 0 || bus.req_ready !== 1'b1 || sb.size() != 0) begin
                errors++;
                $display("FAIL err_req[%0d]: ar_valid cycles=%0d req_ready=%b pending=%0d, required 0 1 0",
                         e, ar_seen, bus.req_ready, sb.size());
            end
        end

        // r_last on beat 1 of a 4-beat burst
        issue_req(4'd2, 64'h8000_0040, 8'd3, 3'd3, 1'b0);
        bd[0] = 64'hAAAA_0000_0000_0001; br[0] = 2'b00; bl[0] = 1'b0; bi[0] = 4'd2;
        bd[1] = 64'hAAAA_0000_0000_0002; br[1] = 2'b00; bl[1] = 1'b1; bi[1] = 4'd2;
        sb.push_back('{bd[0], 2'b00, 1'b0});
        sb.push_back('{bd[1], 2'b10, 1'b1});
        ar_handshake();
        stream(2, 100, -1, viol);
        drain();
        bus.r_valid = 1'b1;
        #1;
        checks++;
        if (viol != 0 || bus.r_ready !== 1'b0 || bus.req_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL err_early_last: viol=%0d r_ready=%b req_ready=%b pending=%0d, required 0 0 1 0",
                     viol, bus.r_ready, bus.req_ready, sb.size());
        end
        bus.r_valid = 1'b0;

        // final beat of a 2-beat burst arrives without r_last
        issue_req(4'd3, 64'h8000_0080, 8'd1, 3'd3, 1'b0);
        bd[0] = 64'hBBBB_0000_0000_0001; br[0] = 2'b00; bl[0] = 1'b0; bi[0] = 4'd3;
        bd[1] = 64'hBBBB_0000_0000_0002; br[1] = 2'b00; bl[1] = 1'b0; bi[1] = 4'd3;
        sb.push_back('{bd[0], 2'b00, 1'b0});
        sb.push_back('{bd[1], 2'b10, 1'b1});
        ar_handshake();
        stream(2, 100, -1, viol);
        drain();
        checks++;
        if (viol != 0 || bus.req_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL err_missing_last: viol=%0d req_ready=%b pending=%0d, required 0 1 0",
                     viol, bus.req_ready, sb.size());
        end
    endtask

    task automatic test_ar_stall();
        int viol;
        issue_req(4'd9, 64'h8000_0200, 8'd1, 3'd3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            bus.r_valid = 1'b1;
            bus.r_data  = 64'hDEAD_DEAD_DEAD_DEAD;
            bus.r_last  = 1'b1;
            bus.r_id    = 4'd9;
            #1;
            checks++;
            if (bus.ar_valid !== 1'b1 || bus.ar_addr !== 64'h8000_0200 || bus.ar_len !== 8'd1 ||
                bus.ar_size !== 3'd3 || bus.ar_id !== 4'd9 || bus.r_ready !== 1'b0) begin
                errors++;
                $display("FAIL ar_stall[%0d]: valid=%b addr=%h len=%h size=%h id=%h r_ready=%b, required 1 80000200 01 3 9 0",
                         k, bus.ar_valid, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_id,
                         bus.r_ready);
            end
            tick();
        end
        ar_handshake();
        bus.r_valid = 1'b0;
        bd[0] = 64'h1111_2222_3333_4444; br[0] = 2'b00; bl[0] = 1'b0; bi[0] = 4'd9;
        bd[1] = 64'h5555_6666_7777_8888; br[1] = 2'b00; bl[1] = 1'b1; bi[1] = 4'd9;
        sb.push_back('{bd[0], 2'b00, 1'b0});
        sb.push_back('{bd[1], 2'b00, 1'b1});
        stream(2, 100, -1, viol);
        drain();
        checks++;
        if (viol != 0 || bus.req_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL ar_stall_done: viol=%0d req_ready=%b pending=%0d, required 0 1 0",
                     viol, bus.req_ready, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int viol;
        issue_req(4'd4, 64'h8000_0300, 8'd3, 3'd3, 1'b0);
        ar_handshake();
        bus.rsp_ready = 1'b0;
        bus.r_valid   = 1'b1;
        bus.r_data    = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.r_resp    = 2'b00;
        bus.r_last    = 1'b0;
        bus.r_id      = 4'd4;
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (bus.ar_valid !== 1'b0 || bus.r_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: ar_valid=%b r_ready=%b rsp_valid=%b req_ready=%b, required 0 0 0 1",
                     bus.ar_valid, bus.r_ready, bus.rsp_valid, bus.req_ready);
        end
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (bus.rsp_valid) seen++;
            tick();
        end
        bus.r_valid = 1'b0;
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_no_beats: rsp_valid cycles=%0d, required 0", seen);
        end
        issue_req(4'd6, 64'h8000_0010, 8'd0, 3'd3, 1'b0);
        sb.push_back('{64'h0123_4567_89AB_CDEF, 2'b00, 1'b1});
        ar_handshake();
        bd[0] = 64'h0123_4567_89AB_CDEF; br[0] = 2'b00; bl[0] = 1'b1; bi[0] = 4'd6;
        stream(1, 100, -1, viol);
        drain();
        checks++;
        if (viol != 0 || bus.req_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_after: viol=%0d req_ready=%b pending=%0d, required 0 1 0",
                     viol, bus.req_ready, sb.size());
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.req_addr   = '0;
        bus.req_len    = '0;
        bus.req_size   = '0;
        bus.req_signed = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.ar_ready   = 1'b0;
        bus.r_valid    = 1'b0;
        bus.r_data     = '0;
        bus.r_resp     = '0;
        bus.r_last     = 1'b0;
        bus.r_id       = '0;
        test_reset();
        test_single_beat();
        test_burst_backpressure();
        test_errors();
        test_ar_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_rd_burst_master.md
Name: axi_rd_burst_master

Overview:
- Parametrised AXI4 read master.
- Accepts one CPU/cache read request at a time, issues one AR transaction (single beat or INCR burst) and returns every R beat through a valid/ready response port backed by a one-entry output register.
- For single-beat reads it performs byte-lane extraction (shift, mask, optional sign-extend) and checks protocol errors.
- Sits between the LSU/ICache and the AXI arbiter.

Parameters:
- DATA_W, 64, AXI data width in bits (power of 2, >=32).
- ADDR_W, 64, address width.
- ID_W, 4, AXI ID width.
- LEN_W, 8, AXI burst-length field width.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_id  in  ID_W  transaction ID
- req_addr  in  ADDR_W  byte address
- req_len  in  LEN_W  beats-1
- req_size  in  3  log2(bytes per beat)
- req_signed  in  1  sign-extend single-beat result
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  consumer ready
- rsp_data  out  DATA_W  beat data
- rsp_resp  out  2  AXI resp of beat
- rsp_last  out  1  final beat of request
- ar_valid  out  1
- ar_ready  in  1
- ar_id  out  ID_W
- ar_addr  out  ADDR_W
- ar_len  out  LEN_W
- ar_size  out  3
- ar_burst  out  2
- r_valid  in  1
- r_ready  out  1
- r_data  in  DATA_W
- r_resp  in  2
- r_last  in  1
- r_id  in  ID_W

Behaviour:
- Reset (sync, reset_n=0 at clk edge): state=IDLE; ar_valid, r_ready, rsp_valid, rsp_last = 0; rsp_data, rsp_resp, ar_id, ar_addr, ar_len, ar_size = 0; ar_burst = 2'b01. Reset mid-transaction abandons it; no beats are returned afterwards.
- States:
  - IDLE: accept a request when req_valid && req_ready. Go to ADDR, or stay in IDLE on an error request.
  - ADDR: wait for AR handshake, then go to DATA.
  - DATA: collect beats; return to IDLE on the R handshake carrying the final beat.
- req_ready = (state==IDLE) && !rsp_valid.
- Request fields are latched on acceptance; later changes on req_* have no effect.
- Error request, detected at acceptance:
  - req_size > log2(DATA_W/8), or
  - req_len==0 and (addr offset + 2^size) > DATA_W/8, or
  - req_len>0 and addr not aligned to 2^size.
- An error request issues no AXI transaction. Next cycle: rsp_valid=1, rsp_data=0, rsp_resp=2'b10, rsp_last=1.
- AR channel:
  - ar_valid is registered: high from the cycle after acceptance until the cycle after ar_valid&&ar_ready.
  - All AR fields are stable while ar_valid=1.
  - ar_addr = req_addr with low log2(DATA_W/8) bits cleared for len==0; req_addr unmodified for bursts.
  - ar_len = req_len, ar_size = req_size, ar_burst = INCR.
- R channel:
  - r_ready = (state==DATA) && (!rsp_valid || rsp_ready).
  - Beat counter (LEN_W bits) clears on AR handshake and increments per R handshake.
- Beat processing: an R handshake loads the output register in the same edge (rsp_valid=1 next cycle).
  - len==0: rsp_data = (r_data >> 8*offset) masked to 2^size bytes, sign-extended from the top kept bit if req_signed, else zero-extended.
  - len>0: rsp_data = r_data unmodified.
- Response status:
  - rsp_resp = r_resp, except forced to 2'b10 when r_id != latched id, or when r_last disagrees with (counter==ar_len).
  - rsp_last = r_last || (counter==ar_len).
  - Leave DATA on the first handshake where r_last=1 or counter==ar_len.
- Output register: holds until rsp_valid && rsp_ready. If rsp_ready=1 and a new beat handshakes in the same cycle, the register reloads with no bubble (full throughput). rsp_valid drops only when consumed with no new load.
- Simultaneous ar_ready on the first ADDR cycle: AR handshake in that cycle, DATA entered next cycle.
- r_valid before the AR handshake is ignored (r_ready=0).

Test Plan:
- Aligned LD, DATA_W=64: addr 0x8000_0000, size 3, len 0; memory returns 0x1122334455667788, resp 0 → single rsp beat, data 0x1122334455667788, resp 0, last=1; ar_addr 0x8000_0000, ar_len 0.
- Unaligned signed byte: addr 0x8000_0005, size 0, signed=1, r_data 0x00_00_F0_00_00_00_00_00 (byte5=0xF0) → ar_addr 0x8000_0000, rsp_data 0xFFFF_FFFF_FFFF_FFF0; with signed=0 → 0x0000_0000_0000_00F0.
- Burst with backpressure: len 3, size 3, beats D0..D3 back-to-back, rsp_ready low for cycles 2-4 → all four beats delivered in order, none lost, r_ready low while register full, rsp_last only on D3, then req_ready=1.
- Errors:
  - Misaligned: addr 0x8000_0006, size 2, len 0 → no ar_valid ever, one rsp with resp 2'b10, data 0, last 1.
  - r_last early: len 3, r_last on beat 1 → beat 1 resp 2'b10, last=1, back to IDLE.
  - Wrong r_id: single-beat read returns r_id ≠ latched id → rsp_resp 2'b10.
- AR stall and reset: ar_ready held low 5 cycles → ar_addr/len/size stable throughout. Asserting reset_n=0 in DATA → next cycle ar_valid=r_ready=rsp_valid=0, state IDLE; a subsequent normal request completes correctly.
